// File: rtl/grant_router_pkg.sv
// rtl/grant_router_pkg.sv - shared types and grant-decode helpers for grant_router
package grant_router_pkg;

    // Widest grant vector the decode helper accepts; NUM_REQS must not exceed it.
    localparam int MAX_REQS = 32;
    localparam int IDX_W    = 5;
    localparam int DEFAULT_NUM_REQS = 5;

    function automatic int tag_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    typedef logic [tag_width(DEFAULT_NUM_REQS)-1:0] tag_t;

    // Lowest set bit wins; multi_hot flags more than one bit set.
    function automatic logic [IDX_W-1:0] onehot_to_idx(
        input  logic [MAX_REQS-1:0] vec,
        output logic                multi_hot
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQS; i++) begin
            if (vec[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        multi_hot = |(vec & (vec - MAX_REQS'(1)));
        return idx;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order tag FIFO for issued requests awaiting a response
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: rtl/grant_router.sv
// rtl/grant_router.sv - captures granted payloads, issues downstream, steers in-order responses back
module grant_router
    import grant_router_pkg::*;
#(
    parameter int NUM_REQS        = 5,
    parameter int DATA_W          = 32,
    parameter int RESP_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQS-1:0]          grants,
    input  logic [NUM_REQS*DATA_W-1:0]   req_data,
    output logic                         ready_for_grant,
    output logic [NUM_REQS-1:0]          req_accept,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [DATA_W-1:0]            mem_req_data,
    input  logic                         mem_resp_valid,
    input  logic [RESP_W-1:0]            mem_resp_data,
    output logic [NUM_REQS-1:0]          resp_valid,
    output logic [RESP_W-1:0]            resp_data,
    output logic                         err_overrun,
    output logic                         err_orphan
);
    localparam int TAG_W = tag_width(NUM_REQS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [TAG_W-1:0]    pending_tag;
    logic [TAG_W-1:0]    fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    cnt;
    logic [MAX_REQS-1:0] grants_ext;
    logic [IDX_W-1:0]    grant_idx_full;
    logic [TAG_W-1:0]    grant_idx;
    logic                grant_multi;
    logic [DATA_W-1:0]   grant_data;
    logic                any_grant;
    logic                capture;
    logic                handshake;
    logic                pop;

    always_comb begin
        grants_ext                 = '0;
        grants_ext[NUM_REQS-1:0]   = grants;
        grant_multi                = 1'b0;
        grant_idx_full             = onehot_to_idx(grants_ext, grant_multi);
        grant_idx                  = grant_idx_full[TAG_W-1:0];
        grant_data                 = req_data[grant_idx*DATA_W +: DATA_W];
    end

    // In-flight count includes the pending request not yet handed downstream.
    assign cnt             = fifo_count + CNT_W'(mem_req_valid);
    assign ready_for_grant = (!mem_req_valid || mem_req_ready) && (cnt < CNT_W'(MAX_OUTSTANDING));
    assign any_grant       = |grants;
    assign capture         = any_grant && ready_for_grant;
    assign handshake       = mem_req_valid && mem_req_ready;
    assign pop             = mem_resp_valid && !fifo_empty;

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (handshake),
        .pop     (pop),
        .din     (pending_tag),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_valid <= 1'b0;
            mem_req_data  <= '0;
            pending_tag   <= '0;
            req_accept    <= '0;
            resp_valid    <= '0;
            resp_data     <= '0;
            err_overrun   <= 1'b0;
            err_orphan    <= 1'b0;
        end else begin
            req_accept <= '0;
            if (capture) begin
                mem_req_valid <= 1'b1;
                mem_req_data  <= grant_data;
                pending_tag   <= grant_idx;
                req_accept    <= NUM_REQS'(1) << grant_idx;
            end else if (handshake) begin
                mem_req_valid <= 1'b0;
            end

            resp_valid <= pop ? (NUM_REQS'(1) << fifo_dout) : '0;
            if (pop) begin
                resp_data <= mem_resp_data;
            end

            if (any_grant && (!ready_for_grant || grant_multi)) begin
                err_overrun <= 1'b1;
            end
            if (mem_resp_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grant_router.sv
// tb/tb_grant_router.sv - self-checking bench for grant_router
module tb_grant_router;
    localparam int NR = 5;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     grants = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic              ready_for_grant;
    logic [NR-1:0]     req_accept;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [DW-1:0]     mem_req_data;
    logic              mem_resp_valid = 1'b0;
    logic [RW-1:0]     mem_resp_data = '0;
    logic [NR-1:0]     resp_valid;
    logic [RW-1:0]     resp_data;
    logic              err_overrun;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grant_router #(
        .NUM_REQS(NR), .DATA_W(DW), .RESP_W(RW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .grants(grants), .req_data(req_data),
        .ready_for_grant(ready_for_grant), .req_accept(req_accept),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .err_overrun(err_overrun), .err_orphan(err_orphan)
    );

    // Reference model: a pending slot plus a queue of requester ids awaiting responses.
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_tag;
    logic [NR-1:0] m_accept;
    logic [NR-1:0] m_rv;
    logic [RW-1:0] m_rd;
    bit            m_ov;
    bit            m_orph;
    int            tagq[$];

    function automatic bit m_ready();
        return (!m_valid || mem_req_ready) && ((tagq.size() + int'(m_valid)) < MO);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_tag = 0; m_accept = '0; m_rv = '0; m_rd = '0;
        m_ov = 0; m_orph = 0; tagq.delete();
    endtask

    task automatic model_step();
        bit rdy;
        bit hs;
        int idx;
        rdy = m_ready();
        hs  = m_valid && mem_req_ready;
        m_accept = '0;
        m_rv     = '0;
        if (mem_resp_valid) begin
            if (tagq.size() > 0) begin
                m_rv = NR'(1) << tagq.pop_front();
                m_rd = mem_resp_data;
            end else begin
                m_orph = 1;
            end
        end
        if (hs) tagq.push_back(m_tag);
        if (grants != '0 && rdy) begin
            idx = 0;
            for (int i = NR - 1; i >= 0; i--) if (grants[i]) idx = i;
            if ($countones(grants) > 1) m_ov = 1;
            m_valid  = 1;
            m_data   = req_data[idx*DW +: DW];
            m_tag    = idx;
            m_accept = NR'(1) << idx;
        end else begin
            if (grants != '0) m_ov = 1;
            if (hs) m_valid = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hCAFE0000 | 32'(i);
    endtask

    task automatic do_reset();
        grants = '0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        reset_n = 0;
        repeat (2) cyc();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_req_valid); end
        checks++; if (req_accept !== '0) begin errors++; $display("FAIL reset_accept: got %b expected 0", req_accept); end
        checks++; if (resp_valid !== '0 || resp_data !== '0) begin errors++; $display("FAIL reset_resp: got %b/%h expected 0/0", resp_valid, resp_data); end
        checks++; if ({err_overrun, err_orphan} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {err_overrun, err_orphan}); end
        checks++; if (ready_for_grant !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_for_grant); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_data = '0;
        req_data[2*DW +: DW] = 32'hCAFE0002;
        mem_req_ready = 1; grants = 5'b00100;
        cyc();
        grants = '0;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== 32'hCAFE0002) begin errors++; $display("FAIL single_issue: got %b/%h expected 1/cafe0002", mem_req_valid, mem_req_data); end
        checks++; if (req_accept !== 5'b00100) begin errors++; $display("FAIL single_accept: got %b expected 00100", req_accept); end
        cyc();
        checks++; if (req_accept !== '0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b/%b expected 00000/0", req_accept, mem_req_valid); end
        cyc();
        mem_resp_valid = 1; mem_resp_data = 32'h11;
        cyc();
        mem_resp_valid = 0;
        checks++; if (resp_valid !== 5'b00100 || resp_data !== 32'h11) begin errors++; $display("FAIL single_resp: got %b/%h expected 00100/11", resp_valid, resp_data); end
        cyc();
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL single_resp_pulse: got %b expected 0", resp_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_lanes();
        mem_req_ready = 0; grants = 5'b00001;
        cyc();
        checks++; if (req_accept !== 5'b00001 || mem_req_data !== 32'hCAFE0000 || err_overrun !== 1'b0) begin errors++; $display("FAIL bp_capture: got %b/%h/%b expected 00001/cafe0000/0", req_accept, mem_req_data, err_overrun); end
        grants = 5'b00010;
        #1;
        checks++; if (ready_for_grant !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", ready_for_grant); end
        cyc();
        checks++; if (err_overrun !== 1'b1 || req_accept !== '0) begin errors++; $display("FAIL bp_drop1: got ov=%b acc=%b expected 1/00000", err_overrun, req_accept); end
        grants = 5'b00100;
        cyc();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== 32'hCAFE0000 || req_accept !== '0) begin errors++; $display("FAIL bp_hold: got %b/%h/%b expected 1/cafe0000/00000", mem_req_valid, mem_req_data, req_accept); end
        grants = '0; mem_req_ready = 1;
        #1;
        checks++; if (ready_for_grant !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b expected 1", ready_for_grant); end
        cyc();
        checks++; if (mem_req_valid !== 1'b0 || err_overrun !== 1'b1) begin errors++; $display("FAIL bp_release: got %b/%b expected 0/1", mem_req_valid, err_overrun); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_lanes();
        mem_req_ready = 1;
        for (int i = 0; i < 5; i++) begin
            grants = NR'(1) << i;
            #1;
            checks++; if (ready_for_grant !== (i < 4)) begin errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, ready_for_grant, (i < 4)); end
            cyc();
            checks++; if (req_accept !== ((i < 4) ? NR'(1) << i : NR'(0))) begin errors++; $display("FAIL b2b_accept%0d: got %b", i, req_accept); end
        end
        grants = '0;
        #1;
        checks++; if (ready_for_grant !== 1'b0 || err_overrun !== 1'b1 || mem_req_data !== 32'hCAFE0003) begin errors++; $display("FAIL b2b_full: got rdy=%b ov=%b data=%h expected 0/1/cafe0003", ready_for_grant, err_overrun, mem_req_data); end
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1; mem_resp_data = 32'hA + 32'(k);
            cyc();
            checks++; if (resp_valid !== NR'(1) << k || resp_data !== 32'hA + 32'(k)) begin errors++; $display("FAIL b2b_resp%0d: got %b/%h", k, resp_valid, resp_data); end
            if (k == 0) begin
                checks++; if (ready_for_grant !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", ready_for_grant); end
            end
        end
        mem_resp_valid = 0;
        cyc();
        checks++; if (resp_valid !== '0 || err_orphan !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b/%b expected 00000/0", resp_valid, err_orphan); end
    endtask

    task automatic test_orphan();
        do_reset();
        mem_resp_valid = 1; mem_resp_data = 32'h55;
        cyc();
        mem_resp_valid = 0;
        checks++; if (resp_valid !== '0 || err_orphan !== 1'b1) begin errors++; $display("FAIL orphan: got %b/%b expected 00000/1", resp_valid, err_orphan); end
        repeat (2) cyc();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
    endtask

    task automatic test_multihot();
        do_reset();
        set_lanes();
        mem_req_ready = 1; grants = 5'b01010;
        cyc();
        grants = '0;
        checks++; if (req_accept !== 5'b00010 || mem_req_data !== 32'hCAFE0001 || err_overrun !== 1'b1) begin errors++; $display("FAIL multihot: got %b/%h/%b expected 00010/cafe0001/1", req_accept, mem_req_data, err_overrun); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        set_lanes();
        mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            grants = NR'(1) << i;
            cyc();
        end
        grants = '0;
        cyc();
        reset_n = 0;
        #1;
        checks++; if ({mem_req_valid, req_accept, resp_valid, err_overrun, err_orphan} !== '0 || mem_req_data !== '0 || resp_data !== '0) begin errors++; $display("FAIL mid_reset: got v=%b acc=%b rv=%b d=%h rd=%h", mem_req_valid, req_accept, resp_valid, mem_req_data, resp_data); end
        cyc();
        reset_n = 1;
        mem_resp_valid = 1; mem_resp_data = 32'h77;
        cyc();
        checks++; if (err_orphan !== 1'b1 || resp_valid !== '0) begin errors++; $display("FAIL mid_late1: got orph=%b rv=%b expected 1/00000", err_orphan, resp_valid); end
        cyc();
        mem_resp_valid = 0;
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL mid_late2: got %b expected 00000", resp_valid); end
    endtask

    task automatic test_random();
        logic [76:0] got;
        logic [76:0] exp;
        int r;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) grants = '0;
            else if (r < 9) grants = NR'(1) << $urandom_range(0, NR - 1);
            else grants = NR'($urandom);
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ($urandom_range(0, 9) < 3);
            mem_resp_data  = $urandom;
            #1;
            checks++; if (ready_for_grant !== m_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", n, ready_for_grant, m_ready()); end
            @(posedge clk);
            model_step();
            #1;
            got = {mem_req_valid, mem_req_data, req_accept, resp_valid, resp_data, err_overrun, err_orphan};
            exp = {m_valid, m_data, m_accept, m_rv, m_rd, m_ov, m_orph};
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_state@%0d: got %h expected %h", n, got, exp); end
        end
        grants = '0; mem_resp_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_orphan();
        test_multihot();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_router.md
Name: grant_router

Overview:
- Consumer end of the round-robin request/grant interface.
- Takes the registered one-hot grant vector from the arbiter and captures the winning requester's payload.
- Issues that payload to a single shared downstream resource over valid/ready.
- Tracks requester IDs in an in-order tag FIFO and steers each in-order response back to the requester that issued it.

Parameters:
- NUM_REQS, 5, number of requesters; grant vector width.
- DATA_W, 32, request payload width per requester.
- RESP_W, 32, response payload width.
- MAX_OUTSTANDING, 4, maximum requests in flight (pending plus issued-awaiting-response); power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- grants  in  NUM_REQS  one-hot or zero grant vector from the arbiter.
- req_data  in  NUM_REQS*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- ready_for_grant  out  1  high when a grant can be absorbed this cycle; the arbiter's requests are gated with it.
- req_accept  out  NUM_REQS  one-cycle pulse to the requester whose payload was captured.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream request ready.
- mem_req_data  out  DATA_W  downstream request payload.
- mem_resp_valid  in  1  downstream response valid; responses always in issue order, no backpressure.
- mem_resp_data  in  RESP_W  downstream response payload.
- resp_valid  out  NUM_REQS  one-hot response strobe.
- resp_data  out  RESP_W  response payload, broadcast to all requesters.
- err_overrun  out  1  sticky; set by a grant that could not be absorbed.
- err_orphan  out  1  sticky; set by a response arriving with no outstanding tag.

Behaviour:
- Reset (asynchronous, reset_n low): clears all outputs, error flags, the pending register and the tag FIFO. A reset in mid-operation discards all in-flight state; responses for those requests are not delivered.
- In-flight count: cnt = FIFO occupancy + mem_req_valid.
- ready_for_grant = (!mem_req_valid || mem_req_ready) && (cnt < MAX_OUTSTANDING). It depends combinationally on mem_req_ready only.
- Capture, when grants != 0 and ready_for_grant:
  - idx = encoded grant; on multi-hot input the lowest set bit wins and err_overrun is set.
  - Next cycle: mem_req_valid=1, mem_req_data=req_data[idx], req_accept[idx]=1 for exactly one cycle, pending tag=idx.
  - Grant-to-mem_req_valid latency is 1 cycle.
- Grant while ready_for_grant is low: the grant is dropped, err_overrun is set, and no req_accept is issued.
- Issue handshake:
  - mem_req_valid and mem_req_data hold stable until mem_req_ready.
  - On handshake the pending tag is pushed into the FIFO.
  - Handshake and new capture in the same cycle is legal: back-to-back issue, one request per cycle.
- Response:
  - On mem_resp_valid with a non-empty FIFO, the head tag is popped.
  - Next cycle: resp_valid[tag]=1 and resp_data=mem_resp_data. Latency is 1 cycle.
  - With an empty FIFO: response dropped, err_orphan set, resp_valid stays 0.
- Simultaneous push and pop leave occupancy unchanged. The FIFO pointers wrap modulo MAX_OUTSTANDING.
- The ready rule guarantees push never overflows. An assertion must fire if push occurs while the FIFO is full.
- Widths: tag width is $clog2(NUM_REQS), occupancy counter is $clog2(MAX_OUTSTANDING)+1; all arithmetic is unsigned.
- resp_valid and req_accept are strictly one-hot or zero.

Decomposition:
- Package grant_router_pkg holds:
  - localparam function for tag width;
  - tag_t typedef;
  - onehot_to_idx function (lowest-set-bit priority, plus a multi-hot detect output).
- Sub-module tag_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width tag width.
  - Ports: push, pop, din, dout, full, empty, count; asynchronous active-low reset.
- grant_router instantiates one tag_fifo and holds the pending register plus response register.

Test Plan:
1. Reset then grants=5'b00100, req_data lane2=32'hCAFE0002, mem_req_ready=1 -> next cycle mem_req_valid=1, mem_req_data=32'hCAFE0002, req_accept=5'b00100; mem_resp_valid with 32'h11 three cycles later -> following cycle resp_valid=5'b00100, resp_data=32'h11.
2. mem_req_ready=0; grants on 3 consecutive cycles (req 0 then 1 then 2) -> only req0 captured; ready_for_grant low from the cycle after capture; grants for req1/req2 set err_overrun; mem_req_data holds lane0 until ready.
3. Ready held high, grants 0,1,2,3,4 back-to-back with no responses -> ready_for_grant drops after the 4th capture (cnt=4); responses 0xA..0xD -> resp_valid walks 00001,00010,00100,01000 in order; ready_for_grant returns after the first response.
4. mem_resp_valid pulse with nothing outstanding -> err_orphan=1 sticky, resp_valid stays 0.
5. grants=5'b01010 -> lane1 captured (req_accept=5'b00010) and err_overrun=1.
6. Three requests issued, reset_n pulsed low mid-stream, then two late mem_resp_valid -> all outputs 0 during reset; after release the first late response sets err_orphan and resp_valid stays 0.
